// File: rtl/button_event_arbiter_pkg.sv
// Purpose : shared FSM state encodings and width helper for the button event arbiter.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
package button_event_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < value) r = b + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/button_event_arbiter_debounce_channel.sv
// Purpose : one input lane - 2-flop sync, debounce counter, stable level, rising-edge pulse.
// Latency : pulse 3+DEBOUNCE_CYCLES edges after a clean rise is first sampled.
// Backpressure: none; pulse is a fire-and-forget single-cycle strobe.
//
// Ports: clock, reset_n (sync active-low), level (raw async input), pulse (1-cycle rising event).
module button_event_arbiter_debounce_channel
  import button_event_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  localparam int CNT_W = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      pulse    <= 1'b0;
      count    <= '0;
    end else begin
      sync_q1  <= level;
      sync_q2  <= sync_q1;
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
      // Any cycle of agreement restarts the count, so only an unbroken run
      // of DEBOUNCE_CYCLES differing samples can flip the stable level.
      if (sync_q2 == stable) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        stable <= sync_q2;
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Purpose : debounced rising-edge events from NUM_INPUTS levels, served round-robin on a valid/ready port.
// Latency : event_valid 5+DEBOUNCE_CYCLES edges after a clean rise; at most one event per 2 cycles.
// Backpressure: event held stable until event_ready; repeat edges on a pending input merge and pulse overrun.
//
// Ports: clock, reset_n (sync active-low), level_in[NUM_INPUTS], event_valid/event_ready/event_id,
//        pending[NUM_INPUTS] (status), overrun (1-cycle merge indication).
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter  int NUM_INPUTS      = 4,
  parameter  int DEBOUNCE_CYCLES = 50000,
  localparam int ID_WIDTH        = clog2_min1(NUM_INPUTS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_INPUTS-1:0] level_in,
  output logic                  event_valid,
  input  logic                  event_ready,
  output logic [ID_WIDTH-1:0]   event_id,
  output logic [NUM_INPUTS-1:0] pending,
  output logic                  overrun
);

  logic [NUM_INPUTS-1:0] pulse_vec;
  logic [NUM_INPUTS-1:0] pending_q;
  logic [NUM_INPUTS-1:0] pending_d;
  logic [NUM_INPUTS-1:0] grant_clr;
  state_t                state_q;
  state_t                state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic [ID_WIDTH-1:0]   rr_ptr_d;
  logic [ID_WIDTH-1:0]   event_id_q;
  logic [ID_WIDTH-1:0]   event_id_d;
  logic                  overrun_q;
  logic                  overrun_d;
  logic                  found;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [ID_WIDTH:0]     idx_w;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
    button_event_arbiter_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_channel (
      .clock   (clock),
      .reset_n (reset_n),
      .level   (level_in[i]),
      .pulse   (pulse_vec[i])
    );
  end

  // Round-robin pick: first pending bit at or above rr_ptr, wrapping once.
  // idx_w carries one extra bit so rr_ptr + k never overflows before the wrap.
  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    idx_w  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx_w = {1'b0, rr_ptr_q} + (ID_WIDTH + 1)'(k);
      if (idx_w >= (ID_WIDTH + 1)'(NUM_INPUTS)) begin
        idx_w = idx_w - (ID_WIDTH + 1)'(NUM_INPUTS);
      end
      if (!found && pending_q[idx_w[ID_WIDTH-1:0]]) begin
        found  = 1'b1;
        sel_id = idx_w[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    event_id_d = event_id_q;
    rr_ptr_d   = rr_ptr_q;
    grant_clr  = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          event_id_d = sel_id;
          state_d    = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (event_ready) begin
          grant_clr[event_id_q] = 1'b1;
          rr_ptr_d = (event_id_q == ID_WIDTH'(NUM_INPUTS - 1)) ? '0 : event_id_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh pulse beats a same-cycle grant clear so the new edge is not lost.
    pending_d = (pending_q & ~grant_clr) | pulse_vec;
    overrun_d = |(pulse_vec & pending_q);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      event_id_q <= '0;
      rr_ptr_q   <= '0;
      pending_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      event_id_q <= event_id_d;
      rr_ptr_q   <= rr_ptr_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
    end
  end

  assign event_valid = (state_q == ST_OFFER);
  assign event_id    = event_id_q;
  assign pending     = pending_q;
  assign overrun     = overrun_q;

endmodule
